// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock period meter: default sizing and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_meas_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 1000000;

  // State encoding kept as plain constants so older tools and netlists read the same codes.
  typedef logic [1:0] meas_state_t;

  localparam meas_state_t ST_IDLE    = 2'd0;
  localparam meas_state_t ST_ARM     = 2'd1;
  localparam meas_state_t ST_MEASURE = 2'd2;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing a single asynchronous bit into the clk domain.
// Latency: 2 clk cycles from a stable input to q.
// Backpressure: none; the input is sampled every cycle.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both stages
//   d     : asynchronous input bit
//   q     : synchronized output bit
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Latency: valid pulses at most 4 clk cycles after a sig_in rising edge meeting setup.
// Backpressure: none; results are overwritten on the next measurement, valid is a 1-cycle pulse.
//   clk, rst_n : system clock, async active-low reset
//   sig_in     : asynchronous square wave under measurement
//   enable     : synchronous enable; low returns to IDLE and clears counters/timeout
//   period     : clk cycles between the last two rises
//   high_time  : clk cycles sig_in was high within that period
//   valid      : one-cycle pulse when period/high_time update
//   timeout    : sticky, set when no rise arrives within TIMEOUT cycles
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  logic sig_sync;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (sig_sync)
  );

  meas_state_t      state_q, state_d;
  logic             sync_dly_q, sync_dly_d;
  logic             rise_q, rise_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    // sync_dly_q lines up with rise_q, so on the rise cycle it already reflects the
    // first high cycle; hcnt counts off the same delayed copy to stay aligned with cnt.
    sync_dly_d = sig_sync;
    rise_d     = sig_sync & ~sync_dly_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
        ST_ARM: begin
          // First edge only establishes the reference point.
          if (rise_q) begin
            state_d = ST_MEASURE;
            cnt_d   = ONE_W;
            hcnt_d  = ONE_W;
          end
        end
        ST_MEASURE: begin
          // Rise is tested first so an edge landing on the timeout cycle still measures.
          if (rise_q) begin
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = ONE_W;
            hcnt_d    = ONE_W;
          end else if (cnt_q >= TIMEOUT_W) begin
            timeout_d = 1'b1;
            state_d   = ST_ARM;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d = cnt_q + ONE_W;
            if (sync_dly_q) begin
              hcnt_d = hcnt_q + ONE_W;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sync_dly_q <= 1'b0;
      rise_q     <= 1'b0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_dly_q <= sync_dly_d;
      rise_q     <= rise_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter with a scoreboard of expected measurements.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_clk_period_meter;

  localparam int W  = 16;
  localparam int TO = 50;

  logic         clk;
  logic         rst_n;
  logic         sig_in;
  logic         enable;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] per;
    logic [W-1:0] hi;
  } exp_t;

  exp_t exp_q[$];

  clk_period_meter #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .enable    (enable),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every valid must match the oldest expected measurement.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got period=%0d high_time=%0d, required no valid", period, high_time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (period !== e.per || high_time !== e.hi) begin
          n_fail++;
          $display("FAIL measurement: got period=%0d high_time=%0d, required period=%0d high_time=%0d",
                   period, high_time, e.per, e.hi);
        end
      end
    end
  end

  task automatic push_exp(input int per, input int hi);
    exp_t e;
    e.per = W'(per);
    e.hi  = W'(hi);
    exp_q.push_back(e);
  endtask

  // Called at a negedge; leaves sig_in low at a negedge. Rise-to-rise spacing is hi+lo.
  task automatic gen_rise(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(negedge clk);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic restart();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d outstanding valids, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sig_in = 1'b0;
    enable = 1'b0;
    #1;
    n_checks++;
    if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got p=%0d h=%0d v=%b t=%b, required all 0", period, high_time, valid, timeout);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (period !== '0) begin n_fail++; $display("FAIL reset_period: got %0d, required 0", period); end
    n_checks++;
    if (high_time !== '0) begin n_fail++; $display("FAIL reset_high: got %0d, required 0", high_time); end
    n_checks++;
    if (timeout !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got v=%b t=%b, required 0 0", valid, timeout);
    end
  endtask

  task automatic test_square(input int per, input int hi, input int n);
    restart();
    for (int k = 0; k < n; k++) begin
      if (k > 0) push_exp(per, hi);
      gen_rise(hi, per - hi);
    end
    wait_drain($sformatf("square_%0d_%0d", per, hi));
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL square_timeout: got %b, required 0", timeout);
    end
  endtask

  task automatic test_timeout();
    restart();
    sig_in = 1'b1;
    for (int i = 1; i <= 53; i++) begin
      @(negedge clk);
      if (i == 3) sig_in = 1'b0;
    end
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b, required 0", timeout); end
    @(negedge clk);
    n_checks++;
    if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b, required 1", timeout); end
    repeat (5) @(negedge clk);
    // Back in ARM: the next rise only arms, the flag stays set until a measurement.
    gen_rise(6, 8);
    n_checks++;
    if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b, required 1", timeout); end
    repeat (6) @(negedge clk);
    push_exp(20, 6);
    gen_rise(3, 10);
    wait_drain("timeout_recover");
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b, required 0", timeout); end
  endtask

  task automatic test_edge_at_timeout();
    restart();
    gen_rise(10, TO - 10);
    push_exp(TO, 10);
    gen_rise(5, 5);
    wait_drain("edge_at_timeout");
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL edge_at_timeout_flag: got %b, required 0", timeout); end
    // One cycle later than the limit: timeout wins, the late edge only re-arms.
    restart();
    gen_rise(10, TO - 9);
    gen_rise(5, 5);
    wait_drain("edge_past_timeout");
    n_checks++;
    if (timeout !== 1'b1) begin n_fail++; $display("FAIL edge_past_timeout_flag: got %b, required 1", timeout); end
    n_checks++;
    if (period !== W'(TO)) begin
      n_fail++;
      $display("FAIL edge_past_timeout_hold: got period=%0d, required %0d", period, TO);
    end
  endtask

  task automatic test_enable_drop();
    restart();
    gen_rise(5, 5);
    push_exp(10, 5);
    gen_rise(5, 3);
    wait_drain("enable_pre");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (period !== W'(10) || high_time !== W'(5)) begin
        n_fail++;
        $display("FAIL enable_hold: got period=%0d high_time=%0d, required 10 5", period, high_time);
      end
      n_checks++;
      if (timeout !== 1'b0) begin n_fail++; $display("FAIL enable_timeout: got %b, required 0", timeout); end
    end
    enable = 1'b1;
    gen_rise(4, 8);
    push_exp(12, 4);
    gen_rise(3, 3);
    wait_drain("enable_post");
  endtask

  task automatic test_reset_mid();
    restart();
    gen_rise(5, 5);
    push_exp(10, 5);
    gen_rise(5, 3);
    wait_drain("reset_mid_pre");
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got p=%0d h=%0d v=%b t=%b, required all 0", period, high_time, valid, timeout);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    gen_rise(6, 9);
    n_checks++;
    if (period !== '0 || high_time !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_arm_only: got p=%0d h=%0d, required 0 0", period, high_time);
    end
    push_exp(15, 6);
    gen_rise(4, 4);
    wait_drain("reset_mid_post");
  endtask

  initial begin
    test_reset();
    test_square(10, 5, 4);
    test_square(7, 2, 4);
    test_timeout();
    test_edge_at_timeout();
    test_enable_drop();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
